// File: rtl/auth_unlocker_if.sv
// auth_unlocker_if: check-request/result handshake plus table write port
// for the credential checker. The master side issues checks and writes
// entries. The slave side (auth_unlocker) returns busy/done/granted/match_idx.
interface auth_unlocker_if #(
    parameter int SYM_W = 5,
    parameter int NSYM  = 4,
    parameter int DEPTH = 8
);
    localparam int CRED_W = NSYM * SYM_W;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              start;
    logic [CRED_W-1:0] user_in;
    logic [CRED_W-1:0] pass_in;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [CRED_W-1:0] wr_user;
    logic [CRED_W-1:0] wr_pass;
    logic              wr_valid;
    logic              busy;
    logic              done;
    logic              granted;
    logic [IDX_W-1:0]  match_idx;

    modport master (
        output start, user_in, pass_in, wr_en, wr_idx, wr_user, wr_pass, wr_valid,
        input  busy, done, granted, match_idx
    );

    modport slave (
        input  start, user_in, pass_in, wr_en, wr_idx, wr_user, wr_pass, wr_valid,
        output busy, done, granted, match_idx
    );
endinterface

// File: rtl/auth_unlocker.sv
// auth_unlocker: credential table plus a linear scanner that owns the unlock
// decision. One entry is examined per cycle. The first valid entry whose
// username matches decides the outcome.
// Optional feature macro: AUTH_LOCKOUT_EN adds the consecutive-failure
// counter and the timed LOCKOUT state. Without it, every failure returns
// straight to IDLE and locked_out is tied low.
module auth_unlocker #(
    parameter int SYM_W       = 5,
    parameter int NSYM        = 4,
    parameter int DEPTH       = 8,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    auth_unlocker_if.slave bus,
    input  logic          relock,
    output logic          lock,
    output logic          locked_out
);
    localparam int CRED_W = NSYM * SYM_W;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NIDX   = 1 << IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_DONE    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t            state_r;
    logic [IDX_W-1:0]  scan_idx_r;
    logic [CRED_W-1:0] cap_user_r;
    logic [CRED_W-1:0] cap_pass_r;
    logic              busy_r;
    logic              done_r;
    logic              granted_r;
    logic [IDX_W-1:0]  match_idx_r;
    logic              lock_r;

    logic [CRED_W-1:0] tbl_user_r  [DEPTH];
    logic [CRED_W-1:0] tbl_pass_r  [DEPTH];
    logic              tbl_valid_r [DEPTH];

    logic [NIDX-1:0]   idx_ok_s;
    logic              wr_ok_s;
    logic              hit_s;
    logic              pass_ok_s;
    logic              last_s;

`ifdef AUTH_LOCKOUT_EN
    localparam int FAIL_W = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;
    localparam int LCNT_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC + 1) : 1;
    logic [FAIL_W-1:0] fail_cnt_r;
    logic [LCNT_W-1:0] lo_cnt_r;
    logic              locked_out_r;
    assign locked_out = locked_out_r;
`else
    assign locked_out = 1'b0;
`endif

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.granted   = granted_r;
    assign bus.match_idx = match_idx_r;
    assign lock          = lock_r;

    // Decode legal write indices and compare the entry under the scan pointer.
    always_comb begin
        idx_ok_s = '0;
        for (int i = 0; i < NIDX; i++) begin
            idx_ok_s[i] = (i < DEPTH);
        end
        wr_ok_s   = bus.wr_en && idx_ok_s[bus.wr_idx] &&
                    ((state_r == ST_IDLE) || (state_r == ST_LOCKOUT));
        hit_s     = tbl_valid_r[scan_idx_r] && (tbl_user_r[scan_idx_r] == cap_user_r);
        pass_ok_s = (tbl_pass_r[scan_idx_r] == cap_pass_r);
        last_s    = (scan_idx_r == IDX_W'(DEPTH - 1));
    end

    // Credential table: writes only land outside SCAN/DONE so a scan sees a frozen table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_user_r[i]  <= '0;
                tbl_pass_r[i]  <= '0;
                tbl_valid_r[i] <= (i == 0);
            end
        end else if (wr_ok_s) begin
            tbl_user_r[bus.wr_idx]  <= bus.wr_user;
            tbl_pass_r[bus.wr_idx]  <= bus.wr_pass;
            tbl_valid_r[bus.wr_idx] <= bus.wr_valid;
        end
    end

    // Control FSM with registered result, lock and lockout outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            scan_idx_r   <= '0;
            cap_user_r   <= '0;
            cap_pass_r   <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            granted_r    <= 1'b0;
            match_idx_r  <= '0;
            lock_r       <= 1'b1;
`ifdef AUTH_LOCKOUT_EN
            fail_cnt_r   <= '0;
            lo_cnt_r     <= '0;
            locked_out_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            // relock always wins; the DONE grant path below respects it
            if (relock) begin
                lock_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        cap_user_r <= bus.user_in;
                        cap_pass_r <= bus.pass_in;
                        scan_idx_r <= '0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit_s) begin
                        granted_r   <= pass_ok_s;
                        match_idx_r <= scan_idx_r;
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end else if (last_s) begin
                        granted_r   <= 1'b0;
                        match_idx_r <= '0;
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        scan_idx_r <= scan_idx_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                    if (granted_r) begin
                        if (!relock) begin
                            lock_r <= 1'b0;
                        end
`ifdef AUTH_LOCKOUT_EN
                        fail_cnt_r <= '0;
`endif
                        state_r <= ST_IDLE;
                    end else begin
`ifdef AUTH_LOCKOUT_EN
                        if (fail_cnt_r == FAIL_W'(MAX_FAIL - 1)) begin
                            fail_cnt_r   <= '0;
                            lo_cnt_r     <= LCNT_W'(LOCKOUT_CYC - 1);
                            locked_out_r <= 1'b1;
                            state_r      <= ST_LOCKOUT;
                        end else begin
                            fail_cnt_r <= fail_cnt_r + FAIL_W'(1);
                            state_r    <= ST_IDLE;
                        end
`else
                        state_r <= ST_IDLE;
`endif
                    end
                end
`ifdef AUTH_LOCKOUT_EN
                ST_LOCKOUT: begin
                    if (lo_cnt_r == '0) begin
                        locked_out_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        lo_cnt_r <= lo_cnt_r - LCNT_W'(1);
                    end
                end
`endif
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_auth_unlocker.sv
// tb_auth_unlocker: directed checks of auth_unlocker with hand-computed
// latencies and results. Covers both builds; the lockout section follows
// AUTH_LOCKOUT_EN.
module tb_auth_unlocker;
    localparam int SYM_W       = 5;
    localparam int NSYM        = 4;
    localparam int DEPTH       = 8;
    localparam int MAX_FAIL    = 3;
    localparam int LOCKOUT_CYC = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic relock;
    logic lock;
    logic locked_out;
    int   n_checks = 0;
    int   n_errors = 0;

    auth_unlocker_if #(.SYM_W(SYM_W), .NSYM(NSYM), .DEPTH(DEPTH)) bus ();

    auth_unlocker #(
        .SYM_W(SYM_W), .NSYM(NSYM), .DEPTH(DEPTH),
        .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYC(LOCKOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .relock(relock), .lock(lock), .locked_out(locked_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic begin_start(input logic [19:0] u, input logic [19:0] p);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.user_in = u;
        bus.pass_in = p;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    // n counts cycles after the start edge; done in cycle E0+n
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_check(input logic [19:0] u, input logic [19:0] p, output int n);
        begin_start(u, p);
        wait_done(1, n);
    endtask

    task automatic wr_entry(input logic [2:0] idx, input logic [19:0] u, input logic [19:0] p,
                            input logic v);
        @(negedge clk);
        bus.wr_en    = 1'b1;
        bus.wr_idx   = idx;
        bus.wr_user  = u;
        bus.wr_pass  = p;
        bus.wr_valid = v;
        @(negedge clk);
        bus.wr_en    = 1'b0;
    endtask

    initial begin
        int   lat;
        int   lo;
        logic seen;

        rst_n = 1'b0; relock = 1'b0;
        bus.start = 1'b0; bus.user_in = 20'h0; bus.pass_in = 20'h0;
        bus.wr_en = 1'b0; bus.wr_idx = 3'd0; bus.wr_user = 20'h0;
        bus.wr_pass = 20'h0; bus.wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_lock",       32'(lock),          32'd1);
        check_val("rst_busy",       32'(bus.busy),      32'd0);
        check_val("rst_done",       32'(bus.done),      32'd0);
        check_val("rst_granted",    32'(bus.granted),   32'd0);
        check_val("rst_match_idx",  32'(bus.match_idx), 32'd0);
        check_val("rst_locked_out", 32'(locked_out),    32'd0);
        rst_n = 1'b1;

        // default entry 0 grants all-zero credentials
        run_check(20'h0, 20'h0, lat);
        check_val("def_latency", 32'(lat),           32'd2);
        check_val("def_granted", 32'(bus.granted),   32'd1);
        check_val("def_idx",     32'(bus.match_idx), 32'd0);
        check_val("def_busy",    32'(bus.busy),      32'd1);
        @(negedge clk);
        check_val("def_lock",    32'(lock),          32'd0);
        check_val("def_idle",    32'(bus.busy),      32'd0);
        check_val("def_done_pulse", 32'(bus.done),   32'd0);

        // relock pulse
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        check_val("relock_lock", 32'(lock), 32'd1);

        // late match at entry 5
        wr_entry(3'd5, 20'h12345, 20'hABCDE, 1'b1);
        run_check(20'h12345, 20'hABCDE, lat);
        check_val("late_latency", 32'(lat),           32'd7);
        check_val("late_granted", 32'(bus.granted),   32'd1);
        check_val("late_idx",     32'(bus.match_idx), 32'd5);
        @(negedge clk);
        check_val("late_lock",    32'(lock),          32'd0);

        // wrong password on entry 5
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        run_check(20'h12345, 20'hABCDF, lat);
        check_val("badpw_latency", 32'(lat),           32'd7);
        check_val("badpw_granted", 32'(bus.granted),   32'd0);
        check_val("badpw_idx",     32'(bus.match_idx), 32'd5);
        @(negedge clk);
        check_val("badpw_lock",    32'(lock),          32'd1);

        // relock held across a granting DONE
        relock = 1'b1;
        run_check(20'h0, 20'h0, lat);
        check_val("relk_done",    32'(bus.done),    32'd1);
        check_val("relk_granted", 32'(bus.granted), 32'd1);
        @(negedge clk);
        check_val("relk_lock",    32'(lock),        32'd1);
        relock = 1'b0;

        // write attempted during SCAN must be dropped; no-match takes DEPTH+1
        begin_start(20'h11111, 20'h0);
        bus.wr_en = 1'b1; bus.wr_idx = 3'd1; bus.wr_user = 20'h0AAAA;
        bus.wr_pass = 20'h0BBBB; bus.wr_valid = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        wait_done(2, lat);
        check_val("nomatch_latency", 32'(lat),           32'd9);
        check_val("nomatch_granted", 32'(bus.granted),   32'd0);
        check_val("nomatch_idx",     32'(bus.match_idx), 32'd0);
        run_check(20'h0AAAA, 20'h0BBBB, lat);
        check_val("busywr_latency", 32'(lat),           32'd9);
        check_val("busywr_granted", 32'(bus.granted),   32'd0);

        // grant clears the failure count, then reset mid-scan
        run_check(20'h0, 20'h0, lat);
        check_val("pre_rst_granted", 32'(bus.granted), 32'd1);
        begin_start(20'h11111, 20'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy",    32'(bus.busy),      32'd0);
        check_val("midrst_done",    32'(bus.done),      32'd0);
        check_val("midrst_lock",    32'(lock),          32'd1);
        check_val("midrst_granted", 32'(bus.granted),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check_val("midrst_no_done", 32'(seen), 32'd0);

        // entry 5 must be gone after reset: failure 1
        run_check(20'h12345, 20'hABCDE, lat);
        check_val("cleared_granted", 32'(bus.granted),   32'd0);
        check_val("cleared_idx",     32'(bus.match_idx), 32'd0);
        run_check(20'h0, 20'h1, lat);
        check_val("fail2_granted", 32'(bus.granted), 32'd0);
        run_check(20'h0, 20'h2, lat);
        check_val("fail3_granted", 32'(bus.granted), 32'd0);
        @(negedge clk);
`ifdef AUTH_LOCKOUT_EN
        check_val("lockout_entry", 32'(locked_out), 32'd1);
        lo = 0;
        seen = 1'b0;
        while (locked_out === 1'b1 && lo < 50) begin
            lo++;
            if (bus.done === 1'b1) seen = 1'b1;
            if (lo == 3) begin
                bus.start = 1'b1; bus.user_in = 20'h0; bus.pass_in = 20'h0;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (4) begin
            if (bus.done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        check_val("lockout_cycles",  32'(lo),   32'(LOCKOUT_CYC));
        check_val("lockout_dropped", 32'(seen), 32'd0);
`else
        lo = 0;
        check_val("nolo_locked_out", 32'(locked_out), 32'd0);
        check_val("nolo_busy",       32'(bus.busy),   32'd0);
`endif
        run_check(20'h0, 20'h0, lat);
        check_val("post_latency", 32'(lat),         32'd2);
        check_val("post_granted", 32'(bus.granted), 32'd1);
        @(negedge clk);
        check_val("post_lock",    32'(lock),        32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
